hs_tx: RTL and testbench
========================

# hs_tx

Transmit end of the team's valid/ready handshake stream. It accepts words from a local producer through a simple write port, buffers them in a small FIFO, and presents them on a valid/ready output. Once presented, a word is held stable until accepted. It drives the upstream side of the handshake pipeline stages used throughout the design, and counts completed transfers for debug.

## Interface
Parameters:
- DATA_WIDTH, 16, width of data words
- DEPTH, 4, FIFO entries; power of two, ≥ 2 (total capacity DEPTH+1 including output register)
- CNT_WIDTH, 16, width of transfer counter

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- wr_en  input  1  producer write strobe
- wr_data  input  DATA_WIDTH  producer word
- wr_full  output  1  no space; writes this cycle are dropped
- overflow  output  1  sticky: a write was attempted while wr_full
- valid  output  1  output word present
- ready  input  1  consumer accepts word this cycle
- data  output  DATA_WIDTH  output word
- level  output  $clog2(DEPTH+1)+1  words held (FIFO count + valid)
- tx_count  output  CNT_WIDTH  completed transfers (valid && ready), wraps

## Operation
- Output register (valid, data) loads when load = ~valid || ready, the same advance rule as downstream stages.
- Load source priority:
  - FIFO head if FIFO non-empty.
  - Otherwise wr_data when wr_en (bypass).
  - Otherwise valid falls to 0 at the edge, and data holds its last value.
- Write accepted when wr_en && ~wr_full. The accepted word goes to the FIFO unless it is consumed by the bypass path the same cycle.
- wr_full = (FIFO count == DEPTH); combinational from registered count. A pop in the same cycle does not free space for a write.
- Write while wr_full: word dropped, overflow set; overflow clears only on rst.
- Simultaneous push and pop on FIFO: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is tracked separately, 0..DEPTH.
- tx_count increments by 1 at each edge where valid && ready; wraps modulo 2^CNT_WIDTH.
- Data ordering strictly FIFO; no word duplicated or lost except dropped overflow writes.

## Timing
- Reset values: valid 0, data 0, wr_full 0, overflow 0, level 0, tx_count 0; FIFO empty.
- rst mid-operation discards all buffered words and the presented word at that edge.
- Latency with FIFO empty and output stage empty or accepted: wr_en at cycle N produces valid=1 and data=wr_data in cycle N+1.
- While valid && ~ready: valid and data are unchanged at the next edge (protocol rule; never withdraw or alter).
- Back-to-back: with ready held high and one write per cycle, throughput is 1 word/cycle, and the FIFO stays empty via bypass.
- level, wr_full and overflow are registered-state-derived and update the cycle after the causing edge.

## Structure
- Shared package hs_pkg: default DATA_WIDTH, transfer-counter width constant, and a function for the level width.
- Sub-module hs_fifo (DEPTH × DATA_WIDTH):
  - Inputs: push, pop, din.
  - Outputs: dout (head, combinational read), count, full, empty.
- hs_tx top holds the output register, bypass mux, overflow flag and tx_count.

## Test plan
- Reset, then idle: valid=0, data=0, level=0, tx_count=0, wr_full=0 for 10 cycles.
- Single write of 16'hA5A5 with ready=1: valid=1, data=A5A5 next cycle; tx_count=1 the cycle after; level back to 0.
- ready=0, write 0x0001..0x0005: data holds 0x0001 with valid high; level=5 and wr_full=1. A sixth write 0x0006 is dropped and overflow=1. Then ready=1: outputs 1..5 in order, one per cycle; tx_count=5.
- Ready toggling 1010… with continuous writes 0..31 (DEPTH=4), stopping writes whenever wr_full: every accepted word is received once, in order. data is never changed while valid && ~ready.
- Full FIFO with simultaneous wr_en and ready: write is dropped (overflow=1), head advances, level decreases by 1.
- rst asserted mid-burst with level=3: next cycle valid=0, level=0, tx_count=0, overflow=0. A subsequent write of 0x1234 appears one cycle later.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared constants and helpers for the handshake transmit path.
package hs_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  // Occupancy must represent FIFO count plus the presented word.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/hs_fifo.sv
// Small circular-buffer FIFO with a combinational head read and a separate occupancy count.
module hs_fifo
  import hs_pkg::*;
#(
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int unsigned PW         = $clog2(DEPTH),
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/hs_tx.sv
// Transmit end of the valid/ready stream: write port -> FIFO -> held output register.
module hs_tx
  import hs_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int unsigned LW         = level_width(DEPTH),
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  overflow,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic [LW-1:0]         level,
  output logic [CNT_WIDTH-1:0]  tx_count
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  tx_count_q, tx_count_d;

  logic                  load, bypass, fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CW-1:0]         fifo_count;

  // Same advance rule as the downstream stages: refill when empty or being drained.
  assign load      = !valid_q || ready;
  assign fifo_pop  = load && !fifo_empty;
  assign bypass    = load && fifo_empty && wr_en;
  assign fifo_push = wr_en && !fifo_full && !bypass;

  hs_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    overflow_d = overflow_q || (wr_en && fifo_full);
    tx_count_d = tx_count_q;
    if (load) begin
      valid_d = !fifo_empty || wr_en;
      if (!fifo_empty) data_d = fifo_dout;
      else if (wr_en)  data_d = wr_data;
    end
    if (valid_q && ready) tx_count_d = tx_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      tx_count_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign valid    = valid_q;
  assign data     = data_q;
  assign overflow = overflow_q;
  assign tx_count = tx_count_q;
  assign wr_full  = fifo_full;
  assign level    = LW'(fifo_count) + LW'(valid_q);

endmodule

// File: tb/tb_hs_tx.sv
// Self-checking bench for hs_tx: occupancy model, scoreboard of accepted words, vector table.
module tb_hs_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;
  localparam int LW    = $clog2(DEPTH + 1) + 1;
  localparam int CAP   = DEPTH + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic            ready = 1'b0;
  logic            wr_full, overflow, valid;
  logic [DW-1:0]   data;
  logic [LW-1:0]   level;
  logic [CNTW-1:0] tx_count;

  always #5 clk = ~clk;

  hs_tx #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_full  (wr_full),
    .overflow (overflow),
    .valid    (valid),
    .ready    (ready),
    .data     (data),
    .level    (level),
    .tx_count (tx_count)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Scoreboard: every word the model says is accepted; head is the word that must be presented.
  logic [DW-1:0]   sb [$];
  logic [DW-1:0]   m_data = '0;
  logic [CNTW-1:0] m_tx = '0;
  logic            m_ovf = 1'b0;
  int              rx_count = 0;

  typedef struct {
    logic          we;
    logic [DW-1:0] wd;
    logic          rdy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [LW-1:0] e_level;
    logic          e_full;
    logic          e_ovf;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_state();
    int n = sb.size();
    check("valid",    32'(valid),    32'(n > 0));
    check("data",     32'(data),     32'(m_data));
    check("level",    32'(level),    32'(n));
    check("wr_full",  32'(wr_full),  32'(n == CAP));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tx_count", 32'(tx_count), 32'(m_tx));
  endtask

  // One clock: drive inputs, compare pre-edge state at the falling edge, advance the model.
  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic rdy);
    int n;
    wr_en   = we;
    wr_data = wd;
    ready   = rdy;
    @(negedge clk);
    check_state();
    n = sb.size();
    if (n > 0 && rdy) begin
      check("xfer_order", 32'(data), 32'(sb.pop_front()));
      m_tx++;
      rx_count++;
    end
    if (we) begin
      if (n == CAP) m_ovf = 1'b1;
      else          sb.push_back(wd);
    end
    @(posedge clk);
    #2;
    if (sb.size() > 0) m_data = sb[0];
  endtask

  task automatic do_reset(input logic we, input logic rdy);
    rst     = 1'b1;
    wr_en   = we;
    wr_data = 16'hDEAD;
    ready   = rdy;
    @(posedge clk);
    #2;
    rst    = 1'b0;
    wr_en  = 1'b0;
    ready  = 1'b0;
    sb.delete();
    m_data = '0;
    m_tx   = '0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int next;
    int guard;
    int rx_start;
    logic rdy_t;

    // Fill with ready low, overflow once, then drain in order.
    tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001, 4'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0001, 4'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 4'd3, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0001, 4'd4, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0001, 4'd5, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 16'h0006, 1'b0, 1'b1, 16'h0001, 4'd5, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 4'd4, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 4'd3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 4'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 4'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 4'd0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    do_reset(1'b0, 1'b0);

    // Reset state and idle.
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_level", 32'(level), 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0);

    // Single write with the consumer ready: one-cycle latency.
    cyc(1'b1, 16'hA5A5, 1'b1);
    check("single_valid", 32'(valid), 32'd1);
    check("single_data",  32'(data),  32'hA5A5);
    cyc(1'b0, '0, 1'b1);
    check("single_tx",    32'(tx_count), 32'd1);
    check("single_level", 32'(level),    32'd0);

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].we, tbl[i].wd, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), 32'(valid),   32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_data", i),  32'(data),    32'(tbl[i].e_data));
      check($sformatf("tbl%0d_level", i), 32'(level),   32'(tbl[i].e_level));
      check($sformatf("tbl%0d_full", i),  32'(wr_full), 32'(tbl[i].e_full));
      check($sformatf("tbl%0d_ovf", i),   32'(overflow), 32'(tbl[i].e_ovf));
    end
    check("tbl_tx_count", 32'(tx_count), 32'd5);

    // Ready toggling with continuous writes, pausing while the model says full.
    rx_start = rx_count;
    next  = 0;
    guard = 0;
    rdy_t = 1'b1;
    while (next < 32 && guard < 400) begin
      if (sb.size() < CAP) begin
        cyc(1'b1, 16'(next), rdy_t);
        next++;
      end else begin
        cyc(1'b0, '0, rdy_t);
      end
      rdy_t = ~rdy_t;
      guard++;
    end
    check("toggle_all_written", 32'(next), 32'd32);
    guard = 0;
    while (sb.size() > 0 && guard < 64) begin
      cyc(1'b0, '0, 1'b1);
      guard++;
    end
    check("toggle_drained", 32'(sb.size()), 32'd0);
    check("toggle_rx", 32'(rx_count - rx_start), 32'd32);

    // Full FIFO with simultaneous write and ready: write dropped, head advances.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < CAP; i++) cyc(1'b1, 16'(16'h0B00 + i), 1'b0);
    check("full_flag", 32'(wr_full), 32'd1);
    cyc(1'b1, 16'hBEEF, 1'b1);
    check("full_drop_level", 32'(level),    32'd4);
    check("full_drop_ovf",   32'(overflow), 32'd1);
    check("full_drop_data",  32'(data),     32'h0B01);

    // Reset mid-burst.
    cyc(1'b0, '0, 1'b1);
    check("pre_rst_level", 32'(level), 32'd3);
    do_reset(1'b1, 1'b1);
    check("mid_rst_valid", 32'(valid),    32'd0);
    check("mid_rst_level", 32'(level),    32'd0);
    check("mid_rst_tx",    32'(tx_count), 32'd0);
    check("mid_rst_ovf",   32'(overflow), 32'd0);
    cyc(1'b1, 16'h1234, 1'b0);
    check("post_rst_valid", 32'(valid), 32'd1);
    check("post_rst_data",  32'(data),  32'h1234);

    // Back-to-back writes with ready held high stay in the bypass path.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 16'(16'h0100 + i), 1'b1);
      check("b2b_level", 32'(level), 32'd1);
      check("b2b_data",  32'(data),  32'(16'h0100 + i));
    end
    guard = 0;
    while (sb.size() > 0 && guard < 16) begin
      cyc(1'b0, '0, 1'b1);
      guard++;
    end
    cyc(1'b0, '0, 1'b0);
    check("final_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
